// File: rtl/sha256_padder_if.sv
// rtl/sha256_padder_if.sv - word-in / padded-block-out handshake bundle for sha256_padder
interface sha256_padder_if;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic [2:0]   in_nbytes;
    logic         out_valid;
    logic         out_ready;
    logic [511:0] out_block;
    logic         out_first;
    logic         out_last;

    modport master (
        output in_valid, in_data, in_last, in_nbytes, out_ready,
        input  in_ready, out_valid, out_block, out_first, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, in_nbytes, out_ready,
        output in_ready, out_valid, out_block, out_first, out_last
    );
endinterface

// File: rtl/sha256_padder.sv
// rtl/sha256_padder.sv - packs 32-bit message words into SHA-256 padded 512-bit blocks
module sha256_padder (
    input  logic            clk,
    input  logic            rst,
    sha256_padder_if.slave  bus
);
    typedef enum logic [1:0] {ACCEPT, EMIT, EMIT_LEN} state_e;

    state_e       state_q;
    logic [3:0]   widx_q;
    logic [63:0]  len_q;
    logic         first_q;
    logic         pend_q;
    logic         pend80_q;
    logic         in_ready_q;
    logic         out_valid_q;
    logic [511:0] out_block_q;
    logic         out_first_q;
    logic         out_last_q;

    logic [2:0]   nbytes_eff;
    logic [6:0]   pos;
    int           pos_int;
    logic [63:0]  len_d;
    logic [511:0] word_blk;
    logic [511:0] final_blk;
    logic [511:0] len_blk;

    assign nbytes_eff = bus.in_last ? bus.in_nbytes : 3'd4;
    assign pos        = {1'b0, widx_q, 2'b00} + {4'b0000, nbytes_eff};
    assign pos_int    = int'(pos);
    assign len_d      = len_q + {58'd0, nbytes_eff, 3'b000};
    // Trailer-only block; the 0x80 lands here only when the data filled the previous block exactly
    assign len_blk    = {(pend80_q ? 8'h80 : 8'h00), 440'd0, len_q};

    always_comb begin
        word_blk = out_block_q;
        for (int w = 0; w < 16; w++) begin
            if (widx_q == w[3:0]) begin
                word_blk[511 - 32*w -: 32] = bus.in_data;
            end
        end
    end

    // Bytes at and after pos are never taken from in_data, so garbage past in_nbytes is dropped
    always_comb begin
        final_blk = word_blk;
        for (int k = 0; k < 64; k++) begin
            if (k == pos_int) begin
                final_blk[511 - 8*k -: 8] = 8'h80;
            end else if (k > pos_int) begin
                final_blk[511 - 8*k -: 8] = 8'h00;
            end
        end
        if (pos <= 7'd55) begin
            final_blk[63:0] = len_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCEPT;
            widx_q      <= 4'd0;
            len_q       <= 64'd0;
            first_q     <= 1'b1;
            pend_q      <= 1'b0;
            pend80_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_block_q <= 512'd0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            case (state_q)
                ACCEPT: begin
                    if (bus.in_valid) begin
                        len_q  <= len_d;
                        widx_q <= widx_q + 4'd1;
                        if (bus.in_last) begin
                            out_block_q <= final_blk;
                            out_valid_q <= 1'b1;
                            in_ready_q  <= 1'b0;
                            out_first_q <= first_q;
                            out_last_q  <= (pos <= 7'd55);
                            pend_q      <= (pos > 7'd55);
                            pend80_q    <= (pos == 7'd64);
                            state_q     <= EMIT;
                        end else begin
                            out_block_q <= word_blk;
                            if (widx_q == 4'd15) begin
                                out_valid_q <= 1'b1;
                                in_ready_q  <= 1'b0;
                                out_first_q <= first_q;
                                out_last_q  <= 1'b0;
                                pend_q      <= 1'b0;
                                state_q     <= EMIT;
                            end
                        end
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        if (pend_q) begin
                            out_block_q <= len_blk;
                            out_first_q <= 1'b0;
                            out_last_q  <= 1'b1;
                            pend_q      <= 1'b0;
                            first_q     <= 1'b0;
                            state_q     <= EMIT_LEN;
                        end else begin
                            out_valid_q <= 1'b0;
                            in_ready_q  <= 1'b1;
                            widx_q      <= 4'd0;
                            state_q     <= ACCEPT;
                            if (out_last_q) begin
                                first_q <= 1'b1;
                                len_q   <= 64'd0;
                            end else begin
                                first_q <= 1'b0;
                            end
                        end
                    end
                end
                EMIT_LEN: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        widx_q      <= 4'd0;
                        len_q       <= 64'd0;
                        first_q     <= 1'b1;
                        state_q     <= ACCEPT;
                    end
                end
                default: state_q <= ACCEPT;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_block = out_block_q;
    assign bus.out_first = out_first_q;
    assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_sha256_padder.sv
// tb/tb_sha256_padder.sv - randomized self-checking bench for sha256_padder against a byte-level padding model
module tb_sha256_padder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sha256_padder_if bus();
    sha256_padder dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;

    byte unsigned mb[$];
    int           mlen[$];
    logic [511:0] exp_blk[$];
    bit           exp_first[$];
    bit           exp_last[$];
    bit           exp_padonly[$];
    int           stall_cnt = 0;
    int           rdy_pct = 100;
    int           gap_pct = 0;

    task automatic add_random_msg(input int len);
        for (int i = 0; i < len; i++) mb.push_back(8'($urandom));
        mlen.push_back(len);
    endtask

    // Standard SHA-256 padding: message, 0x80, zeros to 56 mod 64, 64-bit big-endian bit length
    task automatic build_expected();
        int off;
        off = 0;
        exp_blk.delete(); exp_first.delete(); exp_last.delete(); exp_padonly.delete();
        foreach (mlen[m]) begin
            byte unsigned pq[$];
            logic [63:0]  bitlen;
            int           nb;
            for (int i = 0; i < mlen[m]; i++) pq.push_back(mb[off + i]);
            pq.push_back(8'h80);
            while (pq.size() % 64 != 56) pq.push_back(8'h00);
            bitlen = 64'(mlen[m]) * 64'd8;
            for (int b = 7; b >= 0; b--) pq.push_back(bitlen[8*b +: 8]);
            nb = pq.size() / 64;
            for (int j = 0; j < nb; j++) begin
                logic [511:0] blk;
                for (int k = 0; k < 64; k++) blk[511 - 8*k -: 8] = pq[64*j + k];
                exp_blk.push_back(blk);
                exp_first.push_back(j == 0);
                exp_last.push_back(j == nb - 1);
                exp_padonly.push_back(64*j >= mlen[m] + 1);
            end
            off += mlen[m];
        end
    endtask

    task automatic drive_msgs();
        int off;
        off = 0;
        foreach (mlen[m]) begin
            int len, nw;
            len = mlen[m];
            nw  = (len == 0) ? 1 : (len + 3) / 4;
            for (int w = 0; w < nw; w++) begin
                logic [31:0] d;
                bit          acc;
                int          t;
                for (int b = 0; b < 4; b++) begin
                    int idx;
                    idx = 4*w + b;
                    d[31 - 8*b -: 8] = (idx < len) ? mb[off + idx] : 8'($urandom);
                end
                while ($urandom_range(0, 99) < gap_pct) begin
                    bus.in_valid = 1'b0;
                    @(posedge clk); #1;
                end
                bus.in_valid  = 1'b1;
                bus.in_data   = d;
                bus.in_last   = (w == nw - 1);
                bus.in_nbytes = (w == nw - 1) ? 3'(len - 4*w) : 3'($urandom_range(0, 4));
                acc = 1'b0;
                t   = 0;
                while (!acc && t < 5000) begin
                    acc = bus.in_ready;
                    @(posedge clk); #1;
                    t++;
                end
                if (!acc) begin
                    errors++;
                    $display("FAIL drive_timeout msg%0d word%0d in_ready got=0 exp=1", m, w);
                end
            end
            off += len;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic collect_blocks();
        int           j, t;
        bit           hold, expect_valid, r;
        logic [511:0] pb;
        logic         pf, pl;
        j = 0; t = 0; hold = 0; expect_valid = 0;
        pb = '0; pf = 0; pl = 0;
        while (j < exp_blk.size() && t < 20000) begin
            if (hold) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_block !== pb || bus.out_first !== pf || bus.out_last !== pl) begin
                    errors++;
                    $display("FAIL hold_stable blk%0d got valid=%b first=%b last=%b exp valid=1 first=%b last=%b (block changed=%b)",
                             j, bus.out_valid, bus.out_first, bus.out_last, pf, pl, bus.out_block !== pb);
                end
            end
            if (expect_valid) begin
                checks++;
                if (bus.out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL no_bubble blk%0d out_valid got=%b exp=1", j, bus.out_valid);
                end
                expect_valid = 0;
            end
            if (bus.out_valid === 1'b1) begin
                checks++;
                if (bus.in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL in_ready_during_emit got=%b exp=0", bus.in_ready);
                end
            end
            if (bus.out_valid === 1'b1 && stall_cnt > 0) begin
                r = 0;
                stall_cnt--;
            end else begin
                r = ($urandom_range(0, 99) < rdy_pct);
            end
            bus.out_ready = r;
            if (bus.out_valid === 1'b1 && r) begin
                checks += 3;
                if (bus.out_block !== exp_blk[j]) begin
                    errors++;
                    $display("FAIL block%0d got=%h exp=%h", j, bus.out_block, exp_blk[j]);
                end
                if (bus.out_first !== exp_first[j]) begin
                    errors++;
                    $display("FAIL first%0d got=%b exp=%b", j, bus.out_first, exp_first[j]);
                end
                if (bus.out_last !== exp_last[j]) begin
                    errors++;
                    $display("FAIL last%0d got=%b exp=%b", j, bus.out_last, exp_last[j]);
                end
                if (j + 1 < exp_blk.size() && exp_padonly[j + 1]) expect_valid = 1;
                j++;
            end
            hold = (bus.out_valid === 1'b1) && !r;
            pb = bus.out_block; pf = bus.out_first; pl = bus.out_last;
            @(posedge clk); #1;
            t++;
        end
        bus.out_ready = 1'b0;
        if (j < exp_blk.size()) begin
            errors++;
            $display("FAIL collect_timeout blocks got=%0d exp=%0d", j, exp_blk.size());
        end
    endtask

    task automatic run_msgs();
        build_expected();
        fork
            drive_msgs();
            collect_blocks();
        join
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_after_run out_valid=%b in_ready=%b exp 0/1", bus.out_valid, bus.in_ready);
        end
        mb.delete();
        mlen.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = $urandom;
        bus.in_last   = 1'b1;
        bus.in_nbytes = 3'd2;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks += 2;
        if (bus.out_valid !== 1'b0 || bus.out_block !== 512'd0 || bus.out_first !== 1'b0 || bus.out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs valid=%b first=%b last=%b block_nonzero=%b exp all 0",
                     bus.out_valid, bus.out_first, bus.out_last, bus.out_block !== 512'd0);
        end
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
        end
        bus.in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset in_ready=%b out_valid=%b exp 1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_abc();
        logic [511:0] want;
        want = {32'h61626380, 448'd0, 32'h00000018};
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h616263A5;
        bus.in_last   = 1'b1;
        bus.in_nbytes = 3'd3;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks += 2;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL abc_latency out_valid got=%b exp=1", bus.out_valid);
        end
        if (bus.out_block !== want || bus.out_first !== 1'b1 || bus.out_last !== 1'b1) begin
            errors++;
            $display("FAIL abc_block got=%h first=%b last=%b exp=%h first=1 last=1",
                     bus.out_block, bus.out_first, bus.out_last, want);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abc_drain out_valid got=%b exp=0", bus.out_valid);
        end
        mb.push_back(8'h61); mb.push_back(8'h62); mb.push_back(8'h63);
        mlen.push_back(3);
        rdy_pct = 60; gap_pct = 30;
        run_msgs();
    endtask

    task automatic test_empty();
        bus.in_valid  = 1'b1;
        bus.in_data   = $urandom;
        bus.in_last   = 1'b1;
        bus.in_nbytes = 3'd0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_block !== {32'h80000000, 480'd0} ||
            bus.out_first !== 1'b1 || bus.out_last !== 1'b1) begin
            errors++;
            $display("FAIL empty_block valid=%b got=%h first=%b last=%b exp 80000000 then zeros, 1/1",
                     bus.out_valid, bus.out_block, bus.out_first, bus.out_last);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_boundary_56_64();
        rdy_pct = 100; gap_pct = 0;
        add_random_msg(56);
        run_msgs();
        add_random_msg(64);
        run_msgs();
        rdy_pct = 50; gap_pct = 20;
        add_random_msg(60);
        run_msgs();
    endtask

    task automatic test_stall();
        rdy_pct = 100; gap_pct = 0;
        stall_cnt = 5;
        add_random_msg(64);
        run_msgs();
        stall_cnt = 0;
    endtask

    task automatic test_back_to_back();
        rdy_pct = 100; gap_pct = 0;
        add_random_msg(10);
        add_random_msg(70);
        add_random_msg(0);
        run_msgs();
        rdy_pct = 40; gap_pct = 40;
        add_random_msg(130);
        add_random_msg(56);
        run_msgs();
    endtask

    task automatic test_reset_mid();
        bus.in_valid = 1'b1;
        bus.in_last  = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.in_data   = $urandom;
            bus.in_nbytes = 3'd4;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        bus.in_last = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_during out_valid=%b in_ready=%b exp 0/1", bus.out_valid, bus.in_ready);
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_after out_valid got=%b exp=0", bus.out_valid);
        end
        mb.push_back(8'h61); mb.push_back(8'h62); mb.push_back(8'h63);
        mlen.push_back(3);
        rdy_pct = 100; gap_pct = 0;
        run_msgs();
    endtask

    task automatic test_random();
        int lens[16];
        lens = '{1, 4, 52, 55, 57, 59, 61, 63, 65, 119, 120, 121, 127, 128, 200, 5};
        foreach (lens[i]) begin
            rdy_pct = $urandom_range(30, 100);
            gap_pct = $urandom_range(0, 50);
            add_random_msg(lens[i]);
            if ($urandom_range(0, 1) == 1) add_random_msg($urandom_range(0, 150));
            run_msgs();
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.in_nbytes = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_abc();
        test_empty();
        test_boundary_56_64();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
